// File: rtl/hex_display_ctrl_if.sv
// Signal bundle between a hex display controller and the logic driving it.
// The master modport supplies data and buttons; the slave modport is the controller.
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 2
);
    localparam int DATA_W = 4 * NUM_DIGITS;

    logic [DATA_W-1:0]     data_in;
    logic                  capture_n;
    logic                  show_stored;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic [DATA_W-1:0]     stored_value;
    logic                  capture_pulse;

    modport master (
        output data_in, capture_n, show_stored, blank_lz,
        input  seg, dig_sel, stored_value, capture_pulse
    );

    modport slave (
        input  data_in, capture_n, show_stored, blank_lz,
        output seg, dig_sel, stored_value, capture_pulse
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multiplexed N-digit hex seven-segment controller with a debounced capture button,
// optional display of the captured value and optional leading-zero blanking.
module hex_display_ctrl #(
    parameter int NUM_DIGITS      = 2,
    parameter int REFRESH_DIV     = 1024,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic              CLK,
    input  logic              RST,
    hex_display_ctrl_if.slave bus
);
    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  db_level_q, db_level_d;
    logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic [DATA_W-1:0]     stored_q, stored_d;
    logic                  pulse_q, pulse_d;
    logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

    logic [DATA_W-1:0]     disp_val;
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS:0]   upper_nz;
    logic [3:0]            cur_nib;
    logic                  blank;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        sync1_d = bus.capture_n;
        sync2_d = sync1_q;

        // Debounce: only a run of DEBOUNCE_CYCLES differing samples moves the level.
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        stored_d   = stored_q;
        pulse_d    = 1'b0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = sync2_q;
                if (!sync2_q) begin
                    stored_d = bus.data_in;
                    pulse_d  = 1'b1;
                end
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        ref_cnt_d = ref_cnt_q + REF_W'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        disp_val = bus.show_stored ? stored_q : bus.data_in;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = disp_val[4*i +: 4];
        end
        // upper_nz[i] is set when any nibble at position i or above is nonzero.
        upper_nz[NUM_DIGITS] = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_nz[i] = upper_nz[i+1] | (|nib[i]);
        end

        cur_nib   = nib[idx_q];
        blank     = bus.blank_lz && (idx_q != '0) && !upper_nz[idx_q];
        seg_d     = blank ? 7'h00 : glyph(cur_nib);
        dig_sel_d = NUM_DIGITS'(1) << idx_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            stored_q   <= '0;
            pulse_q    <= 1'b0;
            ref_cnt_q  <= '0;
            idx_q      <= '0;
            seg_q      <= 7'h00;
            dig_sel_q  <= NUM_DIGITS'(1);
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            stored_q   <= stored_d;
            pulse_q    <= pulse_d;
            ref_cnt_q  <= ref_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign bus.seg           = seg_q;
    assign bus.dig_sel       = dig_sel_q;
    assign bus.stored_value  = stored_q;
    assign bus.capture_pulse = pulse_q;
endmodule
